// File: rtl/bf8b_pkg.sv
// Shared widths, state and owner encodings for the memory-bus arbiter.
package bf8b_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_RELEASE = 2'd2
   } arb_state_e;

   localparam logic OWN_FI = 1'b0;
   localparam logic OWN_LS = 1'b1;

   // Width of the BUSY timeout counter; a disabled timeout still keeps one bit.
   function automatic int cnt_width(input int timeout);
      return (timeout > 0) ? $clog2(timeout + 1) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-client arbiter (fetch / load-store) in front of a single handshaked
// memory bus, with optional abort of accesses that are never acknowledged.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | bus free; grant load/store first, else fetch
// ST_BUSY    | mem_req high with latched addr/we/wdata; wait for mem_ready
// ST_RELEASE | access finished; wait for mem_ready low before the next grant
module mem_arbiter
   import bf8b_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fi_req,
   input  logic [ADDR_W-1:0] fi_addr,
   output logic [DATA_W-1:0] fi_rdata,
   output logic              fi_done,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              ls_done,
   output logic              bus_err,
   output logic [ADDR_W-1:0] addr,
   output logic              mem_req,
   output logic              we,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              mem_ready
);

   localparam int                CNT_W    = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   arb_state_e        state_q, state_d;
   logic              owner_q, owner_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              mem_req_q, mem_req_d;
   logic [DATA_W-1:0] fi_rdata_q, fi_rdata_d;
   logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
   logic              fi_done_q, fi_done_d;
   logic              ls_done_q, ls_done_d;
   logic              bus_err_q, bus_err_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWN_FI;
         cnt_q      <= '0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         mem_req_q  <= 1'b0;
         fi_rdata_q <= '0;
         ls_rdata_q <= '0;
         fi_done_q  <= 1'b0;
         ls_done_q  <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         mem_req_q  <= mem_req_d;
         fi_rdata_q <= fi_rdata_d;
         ls_rdata_q <= ls_rdata_d;
         fi_done_q  <= fi_done_d;
         ls_done_q  <= ls_done_d;
         bus_err_q  <= bus_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      mem_req_d  = mem_req_q;
      fi_rdata_d = fi_rdata_q;
      ls_rdata_d = ls_rdata_q;
      fi_done_d  = 1'b0;
      ls_done_d  = 1'b0;
      bus_err_d  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (ls_req) begin
               owner_d   = OWN_LS;
               addr_d    = ls_addr;
               we_d      = ls_we;
               wdata_d   = ls_wdata;
               mem_req_d = 1'b1;
               cnt_d     = '0;
               state_d   = ST_BUSY;
            end else if (fi_req) begin
               owner_d   = OWN_FI;
               addr_d    = fi_addr;
               we_d      = 1'b0;
               mem_req_d = 1'b1;
               cnt_d     = '0;
               state_d   = ST_BUSY;
            end
         end

         ST_BUSY: begin
            if (mem_ready) begin
               if (owner_q == OWN_LS) begin
                  ls_done_d = 1'b1;
                  if (!we_q) begin
                     ls_rdata_d = bus_rdata;
                  end
               end else begin
                  fi_done_d  = 1'b1;
                  fi_rdata_d = bus_rdata;
               end
               mem_req_d = 1'b0;
               we_d      = 1'b0;
               state_d   = ST_RELEASE;
            end else if (TIMEOUT > 0) begin
               // This edge is the TIMEOUT-th unacknowledged BUSY cycle: abort.
               if (cnt_q == CNT_LAST) begin
                  if (owner_q == OWN_LS) begin
                     ls_done_d  = 1'b1;
                     ls_rdata_d = '0;
                  end else begin
                     fi_done_d  = 1'b1;
                     fi_rdata_d = '0;
                  end
                  bus_err_d = 1'b1;
                  mem_req_d = 1'b0;
                  we_d      = 1'b0;
                  state_d   = ST_RELEASE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         ST_RELEASE: begin
            if (!mem_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
            we_d      = 1'b0;
         end
      endcase
   end

   assign addr      = addr_q;
   assign we        = we_q;
   assign bus_wdata = wdata_q;
   assign mem_req   = mem_req_q;
   assign fi_rdata  = fi_rdata_q;
   assign ls_rdata  = ls_rdata_q;
   assign fi_done   = fi_done_q;
   assign ls_done   = ls_done_q;
   assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// two-client traffic scored against a flat memory image.
module tb_mem_arbiter;

   localparam int TO = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       fi_req = 1'b0;
   logic [7:0] fi_addr = 8'h00;
   logic [7:0] fi_rdata;
   logic       fi_done;
   logic       ls_req = 1'b0;
   logic       ls_we = 1'b0;
   logic [7:0] ls_addr = 8'h00;
   logic [7:0] ls_wdata = 8'h00;
   logic [7:0] ls_rdata;
   logic       ls_done;
   logic       bus_err;
   logic [7:0] addr;
   logic       mem_req;
   logic       we;
   logic [7:0] bus_wdata;
   logic [7:0] bus_rdata;
   logic       mem_ready = 1'b0;

   int checks = 0;
   int errors = 0;

   // memory responder: ack after mem_delay+1 cycles of mem_req, commits stores on ack
   logic [7:0] mem_arr [256];
   logic [7:0] ref_mem [256];
   int         mem_delay = 0;
   bit         mem_no_ack = 1'b0;
   int         mem_stale = 0;
   int         mem_cnt = 0;
   int         stale_cnt = 0;

   mem_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .fi_req(fi_req), .fi_addr(fi_addr), .fi_rdata(fi_rdata), .fi_done(fi_done),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_rdata(ls_rdata), .ls_done(ls_done), .bus_err(bus_err),
      .addr(addr), .mem_req(mem_req), .we(we), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   assign bus_rdata = mem_arr[addr];

   always @(posedge clk) begin
      if (mem_req) begin
         stale_cnt <= mem_stale;
         if (!mem_ready && !mem_no_ack) begin
            if (mem_cnt >= mem_delay) begin
               mem_ready <= 1'b1;
               if (we) mem_arr[addr] = bus_wdata;
            end else begin
               mem_cnt <= mem_cnt + 1;
            end
         end
      end else begin
         mem_cnt <= 0;
         if (mem_ready && stale_cnt > 0) stale_cnt <= stale_cnt - 1;
         else mem_ready <= 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // shared scratch for the scenarios
   int         n_ls, n_fi, c_ls, c_fi, n_done, c_done1, c_rise, c_fall, first_c;
   logic [7:0] d_ls, d_fi, exp_ls, fa, la, lw, exp_fd;
   bit         lwe, no_ack, fi_pend, ls_pend, fd, ld, ls_pend0, prev_ready;
   int         pat, dly, quiet;

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem_arr[i] = 8'(i * 7 + 3);
      end

      // ---------------- reset
      tick(); tick();
      check("rst_ctrl", {mem_req, we, fi_done, ls_done, bus_err}, 5'b0);
      check("rst_addr", addr, 8'h00);
      check("rst_wdata", bus_wdata, 8'h00);
      check("rst_rdata", {fi_rdata, ls_rdata}, 16'h0000);
      #2 rst = 1'b1;
      tick(); tick();

      // ---------------- fetch read
      mem_arr[8'h04] = 8'h20;
      fi_addr = 8'h04; fi_req = 1'b1;
      tick();
      check("f_mem_req0", mem_req, 1'b1);
      check("f_addr", addr, 8'h04);
      check("f_we", we, 1'b0);
      check("f_done_early0", fi_done, 1'b0);
      fi_addr = 8'h55;
      tick();
      check("f_mem_req1", mem_req, 1'b1);
      check("f_addr_hold", addr, 8'h04);
      check("f_done_early1", fi_done, 1'b0);
      tick();
      check("f_done", fi_done, 1'b1);
      check("f_rdata", fi_rdata, 8'h20);
      check("f_mem_req_off", mem_req, 1'b0);
      check("f_ls_quiet", ls_done, 1'b0);
      fi_req = 1'b0;
      tick();
      check("f_done_once", fi_done, 1'b0);
      tick(); tick();

      // ---------------- store
      ls_we = 1'b1; ls_addr = 8'hE0; ls_wdata = 8'h05; ls_req = 1'b1;
      tick();
      check("s_we", we, 1'b1);
      check("s_addr", addr, 8'hE0);
      check("s_wdata", bus_wdata, 8'h05);
      check("s_mem_req", mem_req, 1'b1);
      ls_wdata = 8'hFF;
      tick();
      check("s_we_hold", we, 1'b1);
      check("s_wdata_hold", bus_wdata, 8'h05);
      tick();
      check("s_done", ls_done, 1'b1);
      check("s_we_off", we, 1'b0);
      check("s_mem_req_off", mem_req, 1'b0);
      check("s_rdata_kept", ls_rdata, 8'h00);
      check("s_no_err", bus_err, 1'b0);
      check("s_mem", mem_arr[8'hE0], 8'h05);
      ls_req = 1'b0; ls_we = 1'b0;
      tick();
      check("s_done_once", ls_done, 1'b0);
      tick(); tick();

      // ---------------- collision: load wins, fetch follows
      mem_arr[8'h01] = 8'h11; mem_arr[8'h00] = 8'h22;
      ls_addr = 8'h01; ls_we = 1'b0; fi_addr = 8'h00;
      ls_req = 1'b1; fi_req = 1'b1;
      n_ls = 0; n_fi = 0; c_ls = -1; c_fi = -1; d_ls = 8'h00; d_fi = 8'h00;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (ls_done) begin n_ls++; c_ls = c; d_ls = ls_rdata; ls_req = 1'b0; end
         if (fi_done) begin n_fi++; c_fi = c; d_fi = fi_rdata; fi_req = 1'b0; end
      end
      check("c_ls_count", n_ls, 1);
      check("c_fi_count", n_fi, 1);
      check("c_ls_latency", c_ls, 2);
      check("c_ls_first", c_fi > c_ls, 1'b1);
      check("c_gap_min4", (c_fi - c_ls) >= 4, 1'b1);
      check("c_ls_data", d_ls, 8'h11);
      check("c_fi_data", d_fi, 8'h22);

      // ---------------- stale ready held two extra cycles, second fetch pending
      mem_stale = 2;
      mem_arr[8'h10] = 8'h33; mem_arr[8'h11] = 8'h44;
      fi_addr = 8'h10; fi_req = 1'b1;
      n_done = 0; c_done1 = -1; c_rise = -1; c_fall = -1; prev_ready = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (n_done == 1 && c_fall < 0 && !mem_ready) c_fall = c;
         if (n_done == 1 && c_rise < 0 && mem_req) begin
            c_rise = c;
            check("st_prev_ready_low", prev_ready, 1'b0);
         end
         if (fi_done) begin
            n_done++;
            if (n_done == 1) begin
               c_done1 = c;
               check("st_data1", fi_rdata, 8'h33);
               fi_addr = 8'h11;
            end else if (n_done == 2) begin
               check("st_data2", fi_rdata, 8'h44);
               fi_req = 1'b0;
            end
         end
         prev_ready = mem_ready;
      end
      check("st_two_done", n_done, 2);
      check("st_ready_fell", c_fall > c_done1 + 1, 1'b1);
      check("st_rise_after_fall", c_rise, c_fall + 2);
      mem_stale = 0;
      tick(); tick();

      // ---------------- timeout on a load that is never acknowledged
      mem_no_ack = 1'b1;
      mem_arr[8'h30] = 8'h77;
      ls_addr = 8'h30; ls_we = 1'b0; ls_req = 1'b1;
      tick();
      check("t_mem_req", mem_req, 1'b1);
      tick();
      check("t_wait1", {ls_done, bus_err}, 2'b00);
      tick();
      check("t_wait2", {ls_done, bus_err, mem_req}, 3'b001);
      tick();
      check("t_done_err", {ls_done, bus_err}, 2'b11);
      check("t_rdata_zero", ls_rdata, 8'h00);
      check("t_mem_req_off", mem_req, 1'b0);
      ls_req = 1'b0; mem_no_ack = 1'b0;
      tick();
      check("t_pulse_once", {ls_done, bus_err}, 2'b00);
      tick(); tick();

      // ---------------- normal access after the timeout, top address
      mem_arr[8'hFF] = 8'h9C;
      fi_addr = 8'hFF; fi_req = 1'b1;
      tick();
      check("ff_addr", addr, 8'hFF);
      tick(); tick();
      check("ff_done", {fi_done, bus_err}, 2'b10);
      check("ff_rdata", fi_rdata, 8'h9C);
      fi_req = 1'b0;
      tick(); tick(); tick();

      // ---------------- asynchronous reset during a store
      ls_we = 1'b1; ls_addr = 8'h40; ls_wdata = 8'hA5; ls_req = 1'b1;
      tick();
      check("r_busy", {mem_req, we}, 2'b11);
      tick();
      #2 rst = 1'b0;
      #1;
      check("r_async_ctrl", {mem_req, we, ls_done, fi_done, bus_err}, 5'b0);
      check("r_async_rdata", ls_rdata, 8'h00);
      ls_req = 1'b0; ls_we = 1'b0;
      tick();
      check("r_held_ctrl", {mem_req, we, ls_done}, 3'b0);
      tick();
      #2 rst = 1'b1;
      tick();
      fi_addr = 8'h04; fi_req = 1'b1;
      tick();
      check("r_fetch_req", mem_req, 1'b1);
      tick();
      check("r_fetch_early", fi_done, 1'b0);
      tick();
      check("r_fetch_done", fi_done, 1'b1);
      check("r_fetch_data", fi_rdata, 8'h20);
      fi_req = 1'b0;
      tick(); tick(); tick();

      // ---------------- random traffic against a flat memory image
      for (int i = 0; i < 256; i++) begin
         mem_arr[i] = 8'($urandom);
         ref_mem[i] = mem_arr[i];
      end
      exp_ls = 8'h00;
      for (int it = 0; it < 40; it++) begin
         pat    = int'($urandom_range(0, 2));
         dly    = int'($urandom_range(0, 1));
         no_ack = ($urandom_range(0, 7) == 0);
         fa  = 8'($urandom); la = 8'($urandom); lw = 8'($urandom);
         lwe = 1'($urandom_range(0, 1));
         mem_delay = dly; mem_no_ack = no_ack;
         fi_pend = (pat != 1); ls_pend = (pat != 0);
         fi_addr = fa; ls_addr = la; ls_wdata = lw; ls_we = lwe;
         fi_req = fi_pend; ls_req = ls_pend;
         // first completion: TIMEOUT cycles when unacknowledged, else 2 + extra delay
         first_c = no_ack ? TO : 2 + dly;
         n_done = 0;
         for (int c = 0; c < 40 && (fi_pend || ls_pend); c++) begin
            tick();
            fd = fi_done; ld = ls_done; ls_pend0 = ls_pend;
            check("rnd_err_alone", bus_err & ~(fd | ld), 1'b0);
            if (ld) begin
               n_done++;
               if (n_done == 1) check("rnd_latency", c, first_c);
               check("rnd_ls_expected", ls_pend, 1'b1);
               check("rnd_ls_err", bus_err, no_ack);
               if (no_ack) exp_ls = 8'h00;
               else if (!lwe) exp_ls = ref_mem[la];
               else ref_mem[la] = lw;
               check("rnd_ls_rdata", ls_rdata, exp_ls);
               ls_pend = 1'b0; ls_req = 1'b0;
            end
            if (fd) begin
               n_done++;
               if (n_done == 1) check("rnd_latency", c, first_c);
               check("rnd_fi_expected", fi_pend, 1'b1);
               check("rnd_ls_priority", {ls_pend0, ld}, 2'b00);
               check("rnd_fi_err", bus_err, no_ack);
               exp_fd = no_ack ? 8'h00 : ref_mem[fa];
               check("rnd_fi_rdata", fi_rdata, exp_fd);
               fi_pend = 1'b0; fi_req = 1'b0;
            end
         end
         check("rnd_completed", {fi_pend, ls_pend}, 2'b00);
         fi_pend = 1'b0; ls_pend = 1'b0; fi_req = 1'b0; ls_req = 1'b0;
         quiet = 0;
         for (int c = 0; c < 6; c++) begin
            tick();
            if (fi_done || ls_done || bus_err) quiet++;
         end
         check("rnd_no_extra_done", quiet, 0);
      end
      mem_no_ack = 1'b0;
      for (int i = 0; i < 256; i++) begin
         if (mem_arr[i] !== ref_mem[i]) check("rnd_mem_image", mem_arr[i], ref_mem[i]);
      end
      check("rnd_mem_e_probe", mem_arr[la], ref_mem[la]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
